// File: rtl/ising_axil_pkg.sv
// Shared constants and types for the Ising weight-array AXI4-Lite configuration slave.
package ising_axil_pkg;

    localparam logic [1:0]  RESP_OKAY   = 2'b00;
    localparam logic [1:0]  RESP_SLVERR = 2'b10;
    localparam logic [15:0] CTRL_ADDR   = 16'h0000;
    localparam logic [15:0] ID_ADDR     = 16'h0004;

    typedef enum logic [1:0] {
        W_IDLE   = 2'd0,
        W_STROBE = 2'd1,
        W_RESP   = 2'd2
    } w_state_e;

    function automatic logic [1:0] resp_of(input logic ok);
        return ok ? RESP_OKAY : RESP_SLVERR;
    endfunction

endpackage

// File: rtl/ising_weight_axil_if.sv
// AXI4-Lite channel bundle between the configuration master and ising_weight_axil.
interface ising_weight_axil_if #(
    parameter int ADDR_W = 16
);
    logic [ADDR_W-1:0] s_awaddr;
    logic              s_awvalid;
    logic              s_awready;
    logic [31:0]       s_wdata;
    logic              s_wvalid;
    logic              s_wready;
    logic [1:0]        s_bresp;
    logic              s_bvalid;
    logic              s_bready;
    logic [ADDR_W-1:0] s_araddr;
    logic              s_arvalid;
    logic              s_arready;
    logic [31:0]       s_rdata;
    logic [1:0]        s_rresp;
    logic              s_rvalid;
    logic              s_rready;

    modport master (
        output s_awaddr, s_awvalid, s_wdata, s_wvalid, s_bready, s_araddr, s_arvalid, s_rready,
        input  s_awready, s_wready, s_bresp, s_bvalid, s_arready, s_rdata, s_rresp, s_rvalid
    );

    modport slave (
        input  s_awaddr, s_awvalid, s_wdata, s_wvalid, s_bready, s_araddr, s_arvalid, s_rready,
        output s_awready, s_wready, s_bresp, s_bvalid, s_arready, s_rdata, s_rresp, s_rvalid
    );
endinterface

// File: rtl/ising_weight_axil_addr_decode.sv
// Combinational address decoder shared by the read and write channels.
module ising_addr_decode
    import ising_axil_pkg::*;
#(
    parameter int              N         = 8,
    parameter int              ADDR_W    = 16,
    parameter logic [ADDR_W-1:0] CELL_BASE = 16'h0400,
    parameter int              IDX_W     = 6
) (
    input  logic [ADDR_W-1:0] addr,
    output logic              cell_hit,
    output logic [IDX_W-1:0]  cell_idx,
    output logic              ctrl_hit,
    output logic              id_hit,
    output logic              err
);
    localparam logic [ADDR_W-1:0] CTRL_A   = ADDR_W'(CTRL_ADDR);
    localparam logic [ADDR_W-1:0] ID_A     = ADDR_W'(ID_ADDR);
    localparam logic [ADDR_W-3:0] CELL_W   = CELL_BASE[ADDR_W-1:2];
    localparam logic [ADDR_W-3:0] CELL_CNT = (ADDR_W-2)'(N*N);

    logic [ADDR_W-3:0] word_s;
    logic [ADDR_W-3:0] off_s;
    logic              unused_byte_lane_s;

    // Decoding is word-granular; the byte-lane bits carry no meaning here.
    assign word_s             = addr[ADDR_W-1:2];
    assign unused_byte_lane_s = ^addr[1:0];
    assign off_s              = word_s - CELL_W;
    assign cell_hit           = (word_s >= CELL_W) && (off_s < CELL_CNT);
    assign cell_idx           = off_s[IDX_W-1:0];
    assign ctrl_hit           = (word_s == CTRL_A[ADDR_W-1:2]);
    assign id_hit             = (word_s == ID_A[ADDR_W-1:2]);
    assign err                = ~(cell_hit | ctrl_hit | id_hit);

endmodule

// File: rtl/ising_weight_axil.sv
// AXI4-Lite slave owning the cell-array config bus and the oscillator reset register.
// Build option ISING_WEIGHT_LOCK_EN: reject cell writes while ising_rstn is high.
module ising_weight_axil
    import ising_axil_pkg::*;
#(
    parameter int                N         = 8,
    parameter int                ADDR_W    = 16,
    parameter logic [ADDR_W-1:0] CELL_BASE = 16'h0400
) (
    input  logic                clk,
    input  logic                axi_rstn,
    ising_weight_axil_if.slave  axil,
    output logic                cell_wready,
    output logic [N*N-1:0]      cell_wr_addr_match,
    output logic [31:0]         cell_wdata,
    input  logic [N*N*32-1:0]   cell_rdata,
    output logic                ising_rstn
);
    localparam int CELLS = N * N;
    localparam int IDX_W = (CELLS > 1) ? $clog2(CELLS) : 1;

    w_state_e          state_q, state_d;
    logic              aw_full_q, aw_full_d, w_full_q, w_full_d;
    logic [ADDR_W-1:0] awaddr_q, awaddr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic              awready_q, awready_d, wready_q, wready_d;
    logic              cell_wready_q, cell_wready_d;
    logic [CELLS-1:0]  match_q, match_d;
    logic [31:0]       cell_wdata_q, cell_wdata_d;
    logic              bvalid_q, bvalid_d;
    logic [1:0]        bresp_q, bresp_d;
    logic              ctrl_q, ctrl_d;
    logic              arready_q, arready_d, rvalid_q, rvalid_d;
    logic [31:0]       rdata_q, rdata_d;
    logic [1:0]        rresp_q, rresp_d;
    logic              aw_hs_s, w_hs_s, b_hs_s, ar_hs_s, r_hs_s, lock_s, wr_cell_ok_s;
    logic              wr_cell_s, wr_ctrl_s, wr_id_s, wr_err_s;
    logic              rd_cell_s, rd_ctrl_s, rd_id_s, rd_err_s;
    logic [IDX_W-1:0]  wr_idx_s, rd_idx_s;

    // The write decoder looks at the next-state address so the strobe can fire the cycle after capture.
    ising_addr_decode #(.N(N), .ADDR_W(ADDR_W), .CELL_BASE(CELL_BASE), .IDX_W(IDX_W)) u_wr_dec (
        .addr(awaddr_d), .cell_hit(wr_cell_s), .cell_idx(wr_idx_s),
        .ctrl_hit(wr_ctrl_s), .id_hit(wr_id_s), .err(wr_err_s)
    );

    ising_addr_decode #(.N(N), .ADDR_W(ADDR_W), .CELL_BASE(CELL_BASE), .IDX_W(IDX_W)) u_rd_dec (
        .addr(axil.s_araddr), .cell_hit(rd_cell_s), .cell_idx(rd_idx_s),
        .ctrl_hit(rd_ctrl_s), .id_hit(rd_id_s), .err(rd_err_s)
    );

    // AW/W holding registers: filled independently, drained together on the B handshake.
    always_comb begin
        aw_hs_s   = axil.s_awvalid && awready_q;
        w_hs_s    = axil.s_wvalid && wready_q;
        b_hs_s    = bvalid_q && axil.s_bready;
        aw_full_d = ~b_hs_s & (aw_full_q | aw_hs_s);
        w_full_d  = ~b_hs_s & (w_full_q | w_hs_s);
        awaddr_d  = aw_hs_s ? axil.s_awaddr : awaddr_q;
        wdata_d   = w_hs_s ? axil.s_wdata : wdata_q;
        awready_d = ~aw_full_d;
        wready_d  = ~w_full_d;
    end

    // Cell writes are only locked out while the oscillators run, and only in the locking build.
    always_comb begin
`ifdef ISING_WEIGHT_LOCK_EN
        lock_s = ctrl_q;
`else
        lock_s = 1'b0;
`endif
        wr_cell_ok_s = wr_cell_s & ~lock_s;
    end

    // Write FSM: one strobe cycle, then hold the response until accepted.
    always_comb begin
        state_d       = state_q;
        cell_wready_d = 1'b0;
        match_d       = '0;
        cell_wdata_d  = cell_wdata_q;
        bvalid_d      = bvalid_q;
        bresp_d       = bresp_q;
        ctrl_d        = ctrl_q;
        case (state_q)
            W_IDLE: begin
                if (aw_full_d && w_full_d) begin
                    state_d       = W_STROBE;
                    cell_wdata_d  = wdata_d;
                    cell_wready_d = wr_cell_ok_s;
                    match_d       = wr_cell_ok_s ? (CELLS'(1'b1) << wr_idx_s) : '0;
                end else begin
                    state_d = W_IDLE;
                end
            end
            W_STROBE: begin
                state_d  = W_RESP;
                bvalid_d = 1'b1;
                bresp_d  = resp_of(~wr_err_s & ~wr_id_s & ~(wr_cell_s & lock_s));
                ctrl_d   = wr_ctrl_s ? wdata_q[0] : ctrl_q;
            end
            W_RESP: begin
                if (b_hs_s) begin
                    bvalid_d = 1'b0;
                    state_d  = W_IDLE;
                end else begin
                    bvalid_d = 1'b1;
                end
            end
            default: begin
                state_d  = W_IDLE;
                bvalid_d = 1'b0;
            end
        endcase
    end

    // Read channel: sample the addressed source in the AR handshake cycle.
    always_comb begin
        ar_hs_s  = axil.s_arvalid && arready_q;
        r_hs_s   = rvalid_q && axil.s_rready;
        rvalid_d = rvalid_q;
        rdata_d  = rdata_q;
        rresp_d  = rresp_q;
        if (rvalid_q) begin
            rvalid_d = ~r_hs_s;
        end else if (ar_hs_s) begin
            rvalid_d = 1'b1;
            rresp_d  = resp_of(~rd_err_s);
            if (rd_cell_s) begin
                rdata_d = cell_rdata[32*int'(rd_idx_s) +: 32];
            end else if (rd_ctrl_s) begin
                rdata_d = {31'd0, ctrl_q};
            end else if (rd_id_s) begin
                rdata_d = 32'(N);
            end else begin
                rdata_d = 32'd0;
            end
        end else begin
            rvalid_d = 1'b0;
        end
        arready_d = ~rvalid_d;
    end

    // State and output registers.
    always_ff @(posedge clk or negedge axi_rstn) begin
        if (!axi_rstn) begin
            state_q       <= W_IDLE;
            aw_full_q     <= 1'b0;
            w_full_q      <= 1'b0;
            awaddr_q      <= '0;
            wdata_q       <= 32'd0;
            awready_q     <= 1'b0;
            wready_q      <= 1'b0;
            cell_wready_q <= 1'b0;
            match_q       <= '0;
            cell_wdata_q  <= 32'd0;
            bvalid_q      <= 1'b0;
            bresp_q       <= 2'b00;
            ctrl_q        <= 1'b0;
            arready_q     <= 1'b0;
            rvalid_q      <= 1'b0;
            rdata_q       <= 32'd0;
            rresp_q       <= 2'b00;
        end else begin
            state_q       <= state_d;
            aw_full_q     <= aw_full_d;
            w_full_q      <= w_full_d;
            awaddr_q      <= awaddr_d;
            wdata_q       <= wdata_d;
            awready_q     <= awready_d;
            wready_q      <= wready_d;
            cell_wready_q <= cell_wready_d;
            match_q       <= match_d;
            cell_wdata_q  <= cell_wdata_d;
            bvalid_q      <= bvalid_d;
            bresp_q       <= bresp_d;
            ctrl_q        <= ctrl_d;
            arready_q     <= arready_d;
            rvalid_q      <= rvalid_d;
            rdata_q       <= rdata_d;
            rresp_q       <= rresp_d;
        end
    end

    assign axil.s_awready   = awready_q;
    assign axil.s_wready    = wready_q;
    assign axil.s_bvalid    = bvalid_q;
    assign axil.s_bresp     = bresp_q;
    assign axil.s_arready   = arready_q;
    assign axil.s_rvalid    = rvalid_q;
    assign axil.s_rdata     = rdata_q;
    assign axil.s_rresp     = rresp_q;
    assign cell_wready        = cell_wready_q;
    assign cell_wr_addr_match = match_q;
    assign cell_wdata         = cell_wdata_q;
    assign ising_rstn         = ctrl_q;

endmodule

// File: tb/tb_ising_weight_axil.sv
// Scoreboard bench for ising_weight_axil: directed cases plus random traffic against an address-map model.
module tb_ising_weight_axil;
    import ising_axil_pkg::*;

    localparam int N           = 8;
    localparam int ADDR_W      = 16;
    localparam int CELLS       = N * N;
    localparam int NUM_WEIGHTS = 15;
    localparam logic [31:0] CELL_INIT = 32'((NUM_WEIGHTS - 1) / 2);

    typedef struct { logic [31:0] data; logic [1:0] resp; } rexp_t;
    typedef struct { int idx; logic [31:0] data; } sexp_t;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    ising_weight_axil_if #(.ADDR_W(ADDR_W)) ax ();
    logic                  cell_wready;
    logic [CELLS-1:0]      match;
    logic [31:0]           cell_wdata;
    logic [CELLS*32-1:0]   cell_rdata;
    logic                  ising_rstn;

    ising_weight_axil #(.N(N), .ADDR_W(ADDR_W), .CELL_BASE(16'h0400)) dut (
        .clk(clk), .axi_rstn(rstn), .axil(ax),
        .cell_wready(cell_wready), .cell_wr_addr_match(match), .cell_wdata(cell_wdata),
        .cell_rdata(cell_rdata), .ising_rstn(ising_rstn)
    );

    int errors = 0;
    int checks = 0;

    // Stand-in for the cell array: holds a weight per cell, loaded by the strobe.
    logic [31:0] arr [CELLS];
    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < CELLS; i++) arr[i] <= CELL_INIT;
        end else if (cell_wready) begin
            for (int i = 0; i < CELLS; i++) if (match[i]) arr[i] <= cell_wdata;
        end
    end
    always_comb begin
        cell_rdata = '0;
        for (int i = 0; i < CELLS; i++) cell_rdata[32*i +: 32] = arr[i];
    end

    // Reference model of the register map.
    logic [31:0] m_cells [CELLS];
    logic        m_ctrl;
    logic [1:0]  bq [$];
    rexp_t       rq [$];
    sexp_t       sq [$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int cell_of(input logic [15:0] a);
        int w;
        w = int'(a) / 4;
        if (w >= 'h400 / 4 && w < 'h400 / 4 + CELLS) return w - 'h400 / 4;
        return -1;
    endfunction

    function automatic bit expect_write(input logic [15:0] a, input logic [31:0] d);
        int  c;
        bit  lock;
        c    = cell_of(a);
        lock = 1'b0;
`ifdef ISING_WEIGHT_LOCK_EN
        lock = m_ctrl;
`endif
        if (int'(a) / 4 == 0) begin
            bq.push_back(RESP_OKAY);
            m_ctrl = d[0];
            return 1'b0;
        end else if (c >= 0 && !lock) begin
            bq.push_back(RESP_OKAY);
            sq.push_back('{c, d});
            m_cells[c] = d;
            return 1'b1;
        end
        bq.push_back(RESP_SLVERR);
        return 1'b0;
    endfunction

    function automatic void expect_read(input logic [15:0] a);
        int c;
        c = cell_of(a);
        if (int'(a) / 4 == 0)      rq.push_back('{{31'd0, m_ctrl}, RESP_OKAY});
        else if (int'(a) / 4 == 1) rq.push_back('{32'(N), RESP_OKAY});
        else if (c >= 0)           rq.push_back('{m_cells[c], RESP_OKAY});
        else                       rq.push_back('{32'd0, RESP_SLVERR});
    endfunction

    // Monitor: pops the scoreboard whenever the DUT completes a response or strobes a cell.
    always @(negedge clk) begin : monitor
        rexp_t r;
        sexp_t s;
        if (rstn) begin
            if (ax.s_bvalid && ax.s_bready) begin
                if (bq.size() == 0) check("b_unexpected", 64'd1, 64'd0);
                else check("bresp", ax.s_bresp, bq.pop_front());
            end
            if (ax.s_rvalid && ax.s_rready) begin
                if (rq.size() == 0) check("r_unexpected", 64'd1, 64'd0);
                else begin
                    r = rq.pop_front();
                    check("rdata", ax.s_rdata, r.data);
                    check("rresp", ax.s_rresp, r.resp);
                end
            end
            if (cell_wready) begin
                if (sq.size() == 0) check("strobe_unexpected", match, 64'd0);
                else begin
                    s = sq.pop_front();
                    check("strobe_onehot", match, 64'd1 << s.idx);
                    check("strobe_wdata", cell_wdata, s.data);
                end
            end else if (match != '0) begin
                check("match_without_strobe", match, 64'd0);
            end
        end
    end

    task automatic do_write(input logic [15:0] a, input logic [31:0] d,
                            input int aw_dly, input int w_dly, input int bhold);
        int k, aw_k, w_k, st_k, bv_k, hs_k;
        bit strobe, done;
        strobe = expect_write(a, d);
        k = 0; aw_k = -1; w_k = -1; st_k = -1; bv_k = -1; done = 1'b0;
        ax.s_awaddr = a;
        ax.s_wdata  = d;
        while (!done && k < 60) begin
            ax.s_awvalid = (aw_k < 0) && (k >= aw_dly);
            ax.s_wvalid  = (w_k < 0) && (k >= w_dly);
            ax.s_bready  = (bhold == 0) || (bv_k >= 0 && k >= bv_k + bhold);
            @(negedge clk);
            if (w_k >= 0)  check("wready_after_capture", ax.s_wready, 64'd0);
            if (aw_k >= 0) check("awready_after_capture", ax.s_awready, 64'd0);
            if (ax.s_awvalid && ax.s_awready) aw_k = k;
            if (ax.s_wvalid && ax.s_wready)   w_k = k;
            if (cell_wready && st_k < 0)      st_k = k;
            if (ax.s_bvalid && bv_k < 0)      bv_k = k;
            if (bv_k >= 0 && !ax.s_bready)    check("bvalid_held", ax.s_bvalid, 64'd1);
            if (ax.s_bvalid && ax.s_bready)   done = 1'b1;
            @(posedge clk); #1;
            k++;
        end
        ax.s_awvalid = 1'b0;
        ax.s_wvalid  = 1'b0;
        ax.s_bready  = 1'b1;
        if (!done) begin
            check("write_timeout", 64'(a), 64'hFFFF_FFFF);
        end else begin
            hs_k = (aw_k > w_k) ? aw_k : w_k;
            if (strobe) check("strobe_latency", 64'(st_k - hs_k), 64'd1);
            else        check("no_strobe", 64'(st_k), 64'(-1));
            check("bvalid_latency", 64'(bv_k - hs_k), 64'd2);
            check("ising_rstn", ising_rstn, m_ctrl);
        end
    endtask

    task automatic do_read(input logic [15:0] a, input int rhold);
        int k, ar_k, rv_k;
        bit done;
        expect_read(a);
        k = 0; ar_k = -1; rv_k = -1; done = 1'b0;
        ax.s_araddr = a;
        while (!done && k < 40) begin
            ax.s_arvalid = (ar_k < 0);
            ax.s_rready  = (rv_k >= 0) && (k >= rv_k + rhold);
            @(negedge clk);
            if (ax.s_arvalid && ax.s_arready) ar_k = k;
            if (ax.s_rvalid && rv_k < 0)      rv_k = k;
            if (ax.s_rvalid && ax.s_rready)   done = 1'b1;
            @(posedge clk); #1;
            k++;
        end
        ax.s_arvalid = 1'b0;
        ax.s_rready  = 1'b0;
        if (!done) check("read_timeout", 64'(a), 64'hFFFF_FFFF);
        else       check("read_latency", 64'(rv_k - ar_k), 64'd1);
    endtask

    initial begin
        logic [15:0] a;
        logic [31:0] d;
        ax.s_awaddr = '0; ax.s_awvalid = 1'b0; ax.s_wdata = 32'd0; ax.s_wvalid = 1'b0;
        ax.s_bready = 1'b1; ax.s_araddr = '0; ax.s_arvalid = 1'b0; ax.s_rready = 1'b0;
        m_ctrl = 1'b0;
        for (int i = 0; i < CELLS; i++) m_cells[i] = CELL_INIT;

        repeat (3) @(negedge clk);
        check("rst_awready", ax.s_awready, 64'd0);
        check("rst_wready", ax.s_wready, 64'd0);
        check("rst_arready", ax.s_arready, 64'd0);
        check("rst_bvalid", ax.s_bvalid, 64'd0);
        check("rst_rvalid", ax.s_rvalid, 64'd0);
        check("rst_resp_data", {ax.s_bresp, ax.s_rresp, ax.s_rdata}, 64'd0);
        check("rst_cell_if", {cell_wready, cell_wdata}, 64'd0);
        check("rst_match", match, 64'd0);
        check("rst_ising_rstn", ising_rstn, 64'd0);
        rstn = 1'b1;
        @(posedge clk); #1;
        check("ready_after_reset", {ax.s_awready, ax.s_wready, ax.s_arready}, 64'b111);

        do_read(16'h0400, 0);
        do_write(16'h0454, 32'h3, 0, 0, 0);
        do_read(16'h0454, 0);
        do_write(16'h0460, 32'h5, 3, 0, 0);
        do_read(16'h0460, 1);
        do_write(16'h0000, 32'h1, 0, 1, 0);
        do_read(16'h0000, 0);
        do_write(16'h0408, 32'h9, 0, 0, 0);
        do_read(16'h0408, 0);
        do_write(16'h0000, 32'h0, 0, 0, 0);
        do_read(16'h0004, 0);
        do_read(16'h0100, 0);
        do_write(16'h0100, 32'h77, 0, 0, 0);
        do_write(16'h0004, 32'h12, 1, 0, 0);
        do_read(16'h0004, 0);

        fork
            do_write(16'h0428, 32'hAB, 0, 0, 5);
            begin
                repeat (4) @(posedge clk);
                #1;
                do_read(16'h0004, 0);
            end
        join
        do_read(16'h0428, 0);

        for (int i = 0; i < 60; i++) begin
            d = $urandom();
            case ($urandom_range(0, 9))
                0:       a = 16'h0000;
                1:       a = 16'h0004;
                2:       a = 16'h0008 + 16'(4 * $urandom_range(0, 200));
                3:       a = 16'h0500 + 16'(4 * $urandom_range(0, 1000));
                default: a = 16'h0400 + 16'(4 * $urandom_range(0, CELLS - 1)) + 16'($urandom_range(0, 3));
            endcase
            if ($urandom_range(0, 1) == 1)
                do_write(a, d, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 2));
            else
                do_read(a, $urandom_range(0, 2));
        end

        repeat (3) @(posedge clk);
        #1;
        check("bq_drained", 64'(bq.size()), 64'd0);
        check("rq_drained", 64'(rq.size()), 64'd0);
        check("sq_drained", 64'(sq.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
